// File: rtl/traffic_interval_timer.sv
// ---------------------------------------------------------------------------
// traffic_interval_timer
//
// Countdown timer that sits directly after the traffic-light FSM. The FSM
// requests an interval (base / extended / yellow) with a start_timer pulse.
// This block counts that many seconds and then returns a one-cycle expired
// pulse. The three interval lengths are held in programmable 4-bit
// registers. The 1 Hz enable is derived from the system clock by a prescaler.
//
// Ports:
//   clk                     in   system clock, rising edge
//   Reset_Sync              in   asynchronous active-high reset
//   start_timer             in   load selected interval and start counting
//   interval[1:0]           in   00 base, 01 extended, 10 yellow, 11 base
//   Prog_Sync               in   write Time_Value into selected parameter
//   Time_Parameter_Selector in   00 base, 01 extended, 10 yellow, 11 none
//   Time_Value[3:0]         in   new parameter value in seconds
//   expired                 out  one-cycle pulse when the countdown ends
//   one_hz_enable           out  prescaler tick, one clk wide
//   running                 out  countdown active
//   time_left[3:0]          out  remaining whole seconds
// ---------------------------------------------------------------------------
module traffic_interval_timer #(
  parameter int         DIV_COUNT = 100000000,
  parameter logic [3:0] T_BASE    = 4'd6,
  parameter logic [3:0] T_EXT     = 4'd3,
  parameter logic [3:0] T_YEL     = 4'd2
) (
  input  logic       clk,
  input  logic       Reset_Sync,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       Prog_Sync,
  input  logic [1:0] Time_Parameter_Selector,
  input  logic [3:0] Time_Value,
  output logic       expired,
  output logic       one_hz_enable,
  output logic       running,
  output logic [3:0] time_left
);

  localparam int            PW      = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [PW-1:0] LP_LAST = PW'(DIV_COUNT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_prescaler;
  logic [PW-1:0] w_prescaler_next;
  logic [3:0]    r_time_left;
  logic [3:0]    w_time_left_next;
  logic          r_expired;
  logic          w_expired_next;

  logic [3:0]    r_t_base;
  logic [3:0]    r_t_ext;
  logic [3:0]    r_t_yel;

  logic [3:0]    w_sel_value;
  logic [3:0]    w_load_value;
  logic          w_tick;

  // Tick decoded from the registered count so it is glitch-free and exactly
  // one clk wide.
  assign w_tick = (r_prescaler == LP_LAST);

  // Interval selection; code 11 falls back to the base interval.
  always_comb begin
    w_sel_value = r_t_base;
    case (interval)
      2'b01:   w_sel_value = r_t_ext;
      2'b10:   w_sel_value = r_t_yel;
      default: w_sel_value = r_t_base;
    endcase
  end

  // A stored zero is legal; it only becomes the 1 s minimum when loaded.
  assign w_load_value = (w_sel_value == 4'd0) ? 4'd1 : w_sel_value;

  // Prescaler: free-running, but realigned on every start so the first
  // second of a countdown is a full DIV_COUNT cycles long.
  always_comb begin
    w_prescaler_next = r_prescaler + PW'(1);
    if (start_timer || w_tick) begin
      w_prescaler_next = '0;
    end
  end

  // Countdown control. start_timer has priority over the final tick, so a
  // restart on the last second suppresses the expired pulse.
  always_comb begin
    w_state_next     = r_state;
    w_time_left_next = r_time_left;
    w_expired_next   = 1'b0;
    if (start_timer) begin
      w_state_next     = S_RUN;
      w_time_left_next = w_load_value;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_tick) begin
            if (r_time_left <= 4'd1) begin
              w_state_next     = S_IDLE;
              w_time_left_next = 4'd0;
              w_expired_next   = 1'b1;
            end else begin
              w_time_left_next = r_time_left - 4'd1;
            end
          end
        end
        default: begin
          w_state_next     = S_IDLE;
          w_time_left_next = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      r_state     <= S_IDLE;
      r_prescaler <= '0;
      r_time_left <= 4'd0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_prescaler <= w_prescaler_next;
      r_time_left <= w_time_left_next;
      r_expired   <= w_expired_next;
    end
  end

  // Parameter registers. A load in the same cycle reads the old value
  // because the selection above sees the current register contents.
  always_ff @(posedge clk or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      r_t_base <= T_BASE;
      r_t_ext  <= T_EXT;
      r_t_yel  <= T_YEL;
    end else if (Prog_Sync) begin
      case (Time_Parameter_Selector)
        2'b00:   r_t_base <= Time_Value;
        2'b01:   r_t_ext  <= Time_Value;
        2'b10:   r_t_yel  <= Time_Value;
        default: ;
      endcase
    end
  end

  assign expired       = r_expired;
  assign one_hz_enable = w_tick;
  assign running       = (r_state == S_RUN);
  assign time_left     = r_time_left;

endmodule

// File: doc/traffic_interval_timer.md
Name: traffic_interval_timer

Overview:
- Timer stage directly downstream of the traffic-light FSM.
- Consumes the FSM's `start_timer` and `interval[1:0]`, and returns the one-cycle `expired` pulse the FSM waits on.
- Holds the three programmable time parameters (base, extended, yellow) and derives the 1 Hz enable from the system clock.

Parameters:
- DIV_COUNT, 100000000: clk cycles per 1 s tick; minimum 2; benches use 4.
- T_BASE, 6: reset value of the base-interval register, in seconds (4 bit).
- T_EXT, 3: reset value of the extended-interval register, in seconds.
- T_YEL, 2: reset value of the yellow-interval register, in seconds.

Ports:
- clk  in  1  system clock, rising edge.
- Reset_Sync  in  1  asynchronous, active-high reset.
- start_timer  in  1  from FSM; load and start the countdown.
- interval  in  2  from FSM; 00 base, 01 extended, 10 yellow, 11 treated as base.
- Prog_Sync  in  1  synchronized program strobe; write Time_Value into the selected parameter.
- Time_Parameter_Selector  in  2  00 base, 01 extended, 10 yellow, 11 no register (write ignored).
- Time_Value  in  4  new parameter value, in seconds.
- expired  out  1  to FSM; one-cycle pulse when the countdown reaches 0.
- one_hz_enable  out  1  prescaler tick, one clk wide.
- running  out  1  countdown active.
- time_left  out  4  remaining whole seconds.

Behaviour:
- Reset (async, Reset_Sync=1, immediate, no clock needed):
  - expired=0, running=0, time_left=0, prescaler=0, one_hz_enable=0.
  - Parameter registers return to T_BASE, T_EXT, T_YEL.
- Prescaler:
  - Counts 0..DIV_COUNT-1 and wraps; width clog2(DIV_COUNT).
  - one_hz_enable = (prescaler == DIV_COUNT-1), decoded from the registered count.
  - Free-running, but cleared to 0 on any edge where start_timer=1.
- Load:
  - At an edge with start_timer=1: time_left <= selected parameter, running <= 1, prescaler <= 0, expired <= 0.
  - A selected value of 0 loads as 1 (minimum 1 s).
  - start_timer is level-sensitive: each high cycle reloads. The FSM drives it for one cycle.
- Countdown:
  - At an edge with running=1, one_hz_enable=1 and start_timer=0: time_left decrements.
  - If time_left was 1: time_left <= 0, running <= 0, expired <= 1.
- Expired pulse:
  - expired is registered and high for exactly one clk cycle.
  - It is cleared at the next edge.
- Latency: start_timer sampled at edge E0 with loaded value V gives expired high in the cycle after edge E0 + V*DIV_COUNT.
- Idle (running=0):
  - time_left holds 0; no further pulses.
  - Prescaler still runs, so one_hz_enable keeps ticking.
- Programming:
  - At an edge with Prog_Sync=1: the selected register <= Time_Value. Value 0 is stored as 0 and clamped only at load.
  - Selector 11: no register changes.
  - A write during a countdown does not alter the count in progress; it takes effect at the next load.
- Simultaneous events:
  - start_timer + Prog_Sync on the same register at the same edge: the load uses the pre-write value.
  - start_timer at the same edge as the final tick: the restart wins and no expired pulse is produced.
  - start_timer while running: restarts with no intermediate pulse.
- Reset mid-countdown:
  - The countdown is aborted with outputs as in reset; no pulse after release.
  - Programmed values are lost.
- State summary (running flag):
  - IDLE -> RUN on start_timer.
  - RUN -> RUN on start_timer (reload).
  - RUN -> IDLE on final tick (expired).
  - Any -> IDLE on Reset_Sync.

Test Plan (DIV_COUNT=4, defaults 6/3/2):
- Reset, then start_timer pulse with interval=00 at edge E0: expired high for exactly one cycle after edge E0+24; running=1 from E0 to E0+24; time_left steps 6,5,...,1,0 every 4 clks.
- interval=10, 01 and 11, one at a time: expired after 8, 12 and 24 clks respectively; no pulse in between.
- Prog_Sync with selector=01 and Time_Value=5, then start with interval=01: expired after 20 clks. Assert Reset_Sync, restart: expired after 12 clks. Selector=11 write of 9: no timing change.
- Program yellow=0, start with interval=10: expired after 4 clks. Program base=15: expired after 60 clks (4-bit maximum, no wrap).
- Start base at E0, re-assert start_timer at E0+10: a single expired pulse after E0+34. Start coinciding with the final tick: no pulse; the new countdown proceeds.
- Assert Reset_Sync mid-count, between clk edges, at time_left=3: expired, running and time_left go to 0 before the next edge. No expired pulse after release until a new start_timer.
